// File: rtl/clock_divider_multi.sv
// N_CH-channel clock divider with per-channel ratio, enable, tick and error flag.
// Define CLKDIV_SYNC_EN to add sync_start (forced phase-aligned restart).
`timescale 1ns/1ps
module clock_divider_multi #(
  parameter int N_CH    = 4,
  parameter int RATIO_W = 32
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [N_CH-1:0]          enable,
  input  logic [N_CH*RATIO_W-1:0]  ratio,
`ifdef CLKDIV_SYNC_EN
  input  logic                     sync_start,
`endif
  output logic [N_CH-1:0]          clk_out,
  output logic [N_CH-1:0]          tick,
  output logic [N_CH-1:0]          ratio_err
);

  typedef enum logic [1:0] {
    ST_START,
    ST_RUN,
    ST_ILL
  } st_t;

  localparam logic [RATIO_W-1:0] ONE_W = 1;
  localparam logic [RATIO_W-1:0] TWO_W = 2;
  localparam logic [RATIO_W:0]   ONE_X = 1;

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_start;
`else
  assign sync = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [RATIO_W-1:0] r;
    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] act;
    logic [RATIO_W:0]   half;
    logic [RATIO_W:0]   nxt;
    st_t                st;
    logic               co_q;
    logic               tk_q;
    logic               er_q;
    logic               en;
    logic               legal;
    logic               term;
    logic               start;
    logic               go_ok;
    logic               go_bad;
    logic               step;
    logic               hold;

    assign r     = ratio[i*RATIO_W +: RATIO_W];
    assign en    = enable[i];
    assign legal = (r >= TWO_W);

    // one extra bit keeps (act+1) and (cnt+1) exact at all-ones
    assign half  = ({1'b0, act} + ONE_X) >> 1;
    assign nxt   = {1'b0, cnt} + ONE_X;

    assign term  = (st == ST_RUN) &&
                   (cnt == act - ONE_W);
    assign start = (st != ST_RUN) || term || sync;

    assign go_ok  = en & start & legal;
    assign go_bad = en & start & ~legal;
    assign step   = en & ~start;
    assign hold   = ~en;

    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt  <= '0;
        act  <= '0;
        st   <= ST_START;
        co_q <= 1'b0;
        tk_q <= 1'b0;
        er_q <= 1'b0;
      end else begin
        unique case (1'b1)
          go_ok: begin
            act  <= r;
            cnt  <= '0;
            co_q <= 1'b1;
            tk_q <= 1'b1;
            er_q <= 1'b0;
            st   <= ST_RUN;
          end
          go_bad: begin
            co_q <= 1'b0;
            tk_q <= 1'b0;
            er_q <= 1'b1;
            st   <= ST_ILL;
          end
          step: begin
            cnt  <= nxt[RATIO_W-1:0];
            co_q <= (nxt < half);
            tk_q <= 1'b0;
          end
          hold: begin
            tk_q <= 1'b0;
          end
        endcase
      end
    end

    assign clk_out[i]   = co_q;
    assign tick[i]      = tk_q;
    assign ratio_err[i] = er_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomised + directed bench for clock_divider_multi.
// Reference model tracks period position/length per channel.
`timescale 1ns/1ps
module tb_clock_divider_multi;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   enable;
  logic [N*W-1:0] ratio;
  logic           sync_start;
  logic [N-1:0]   clk_out;
  logic [N-1:0]   tick;
  logic [N-1:0]   ratio_err;

  int n_cmp = 0;
  int n_bad = 0;

  longint m_pos [N];
  longint m_per [N];
  bit     m_run [N];
  bit     m_err [N];
  bit     m_tick[N];

  clock_divider_multi #(
    .N_CH    (N),
    .RATIO_W (W)
  ) dut (
    .clk_in     (clk),
    .reset      (reset),
    .enable     (enable),
    .ratio      (ratio),
`ifdef CLKDIV_SYNC_EN
    .sync_start (sync_start),
`endif
    .clk_out    (clk_out),
    .tick       (tick),
    .ratio_err  (ratio_err)
  );

  always #5 clk = ~clk;

  task automatic set_ratio(input int ch, input longint r);
    ratio[ch*W +: W] = r[W-1:0];
  endtask

  // behavioural model: one clk_in edge
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      longint r;
      r = longint'(ratio[i*W +: W]);
      if (reset) begin
        m_run[i]  = 0;
        m_err[i]  = 0;
        m_pos[i]  = 0;
        m_per[i]  = 0;
        m_tick[i] = 0;
      end else if (enable[i]) begin
        if (!m_run[i] || m_pos[i] == m_per[i] - 1 ||
            sync_start) begin
          if (r >= 2) begin
            m_per[i]  = r;
            m_pos[i]  = 0;
            m_run[i]  = 1;
            m_err[i]  = 0;
            m_tick[i] = 1;
          end else begin
            m_run[i]  = 0;
            m_err[i]  = 1;
            m_tick[i] = 0;
          end
        end else begin
          m_pos[i]  = m_pos[i] + 1;
          m_tick[i] = 0;
        end
      end else begin
        m_tick[i] = 0;
      end
    end
  endtask

  function automatic bit exp_clk(input int i);
    return m_run[i] && (m_pos[i] < (m_per[i] + 1) / 2);
  endfunction

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      assert (clk_out[i] === exp_clk(i)) else begin
        n_bad++;
        $error("FAIL clk_out[%0d] got %b exp %b t=%0t",
               i, clk_out[i], exp_clk(i), $time);
      end
      n_cmp++;
      assert (tick[i] === m_tick[i]) else begin
        n_bad++;
        $error("FAIL tick[%0d] got %b exp %b t=%0t",
               i, tick[i], m_tick[i], $time);
      end
      n_cmp++;
      assert (ratio_err[i] === m_err[i]) else begin
        n_bad++;
        $error("FAIL ratio_err[%0d] got %b exp %b t=%0t",
               i, ratio_err[i], m_err[i], $time);
      end
    end
  endtask

  task automatic chk(input string tag,
                     input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got %b exp %b t=%0t",
             tag, got, exp, $time);
    end
  endtask

  task automatic chk_found(input string tag, input bit ok);
    n_cmp++;
    assert (ok) else begin
      n_bad++;
      $error("FAIL %s timed out t=%0t", tag, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit found;
    reset      = 1'b1;
    enable     = '0;
    ratio      = '0;
    sync_start = 1'b0;
    set_ratio(0, 2);
    set_ratio(1, 3);
    set_ratio(2, 10);
    set_ratio(3, 100);
    enable = 4'hf;
    @(negedge clk);
    step();
    chk("reset_clk", clk_out, 4'h0);
    chk("reset_tick", tick, 4'h0);
    chk("reset_err", ratio_err, 4'h0);

    reset = 1'b0;
    step();
    chk("first_rise", clk_out, 4'hf);
    chk("first_tick", tick, 4'hf);
    repeat (250) step();

    // ratio change 4 -> 6 mid-period
    set_ratio(0, 4);
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      found = m_tick[0] && (m_per[0] == 4);
    end
    chk_found("wait_r4", found);
    step();
    set_ratio(0, 6);
    repeat (20) step();

    // illegal ratios on channel 1
    set_ratio(1, 0);
    repeat (5) step();
    chk("err0", ratio_err & 4'h2, 4'h2);
    set_ratio(1, 1);
    repeat (3) step();
    chk("err1", ratio_err & 4'h2, 4'h2);
    set_ratio(1, 7);
    step();
    chk("r7_clk", clk_out & 4'h2, 4'h2);
    chk("r7_tick", tick & 4'h2, 4'h2);
    chk("r7_err", ratio_err & 4'h2, 4'h0);
    repeat (20) step();

    // enable drop on channel 2 at count 3
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      found = m_run[2] && (m_pos[2] == 3);
    end
    chk_found("wait_c3", found);
    enable[2] = 1'b0;
    repeat (5) step();
    enable[2] = 1'b1;
    repeat (30) step();

    // all-ones ratio, then mid-period reset
    ratio = '1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (60) step();
    chk("ones_high", clk_out, 4'hf);
    reset = 1'b1;
    step();
    chk("mid_rst_clk", clk_out, 4'h0);
    chk("mid_rst_tick", tick, 4'h0);
    reset = 1'b0;
    repeat (5) step();

    // randomised traffic
    for (int i = 0; i < N; i++)
      set_ratio(i, $urandom_range(2, 9));
    repeat (400) begin
      enable = N'($urandom);
      if ($urandom_range(0, 3) != 0) enable = 4'hf;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0)
          set_ratio(i, $urandom_range(0, 12));
      reset = ($urandom_range(0, 63) == 0);
`ifdef CLKDIV_SYNC_EN
      sync_start = ($urandom_range(0, 31) == 0);
`endif
      step();
    end
    reset      = 1'b0;
    sync_start = 1'b0;

`ifdef CLKDIV_SYNC_EN
    // phase-aligned restart
    set_ratio(0, 3);
    set_ratio(1, 5);
    set_ratio(2, 3);
    set_ratio(3, 5);
    enable = 4'h7;
    repeat ($urandom_range(4, 11)) step();
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    chk("sync_clk", clk_out & 4'h7, 4'h7);
    chk("sync_tick", tick & 4'h7, 4'h7);
    repeat (20) step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Parametrised, multi-channel successor to the single-ratio clock divider.
- Derives N_CH independent divided clocks from one input clock, each with its own runtime ratio and enable.
- Ratio changes apply only at period boundaries, so there are no runt pulses.
- Also provides a one-cycle period-start tick per channel and flags illegal ratios. Sits in the clocking/timebase area, feeding slow-strobe consumers and test logic.

Parameters:
- N_CH, 4, number of independent divider channels (1..32).
- RATIO_W, 32, width of each channel's ratio field.

Ports:
- clk_in  input  1  source clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  N_CH  per-channel run enable; bit i controls channel i.
- ratio  input  N_CH*RATIO_W  packed divide ratios; channel i uses bits [i*RATIO_W +: RATIO_W].
- clk_out  output  N_CH  divided clock per channel (registered).
- tick  output  N_CH  one-cycle pulse on each period start per channel (registered).
- ratio_err  output  N_CH  high while channel i holds an illegal ratio (<2).

Behaviour:
- Reset (reset=1 at a clk_in edge): per channel count=0, clk_out=0, tick=0, ratio_err=0, channel placed in START state. Reset has priority over everything; mid-period reset aborts the period immediately.
- Per channel states:
  - START: waiting to begin a period.
  - RUN: counting.
  - ILLEGAL: ratio <2 was sampled.
- Ratio sampling: ratio[i] is captured into shadow register act only on a period-start edge. Changes between starts are ignored until the next start.
- Period-start edge: occurs when enable[i]=1 and the channel is in START, ILLEGAL, or RUN with count==act-1. On that edge, with sampled R:
  - If R>=2: act<=R, count<=0, clk_out<=1, tick<=1, ratio_err<=0, state RUN.
  - If R<2: clk_out<=0, tick<=0, ratio_err<=1, state ILLEGAL. R is re-sampled every enabled edge until legal; the first legal edge is a period start.
- RUN, non-terminal edge: count<=count+1; clk_out<=(count+1 < H) where H=(act+1)>>1, computed in RATIO_W+1 bits (no overflow at all-ones); tick<=0.
- Timing:
  - Output period = act clk_in cycles.
  - clk_out high for ceil(act/2) cycles and low for floor(act/2). Example: act=5 gives 3 high, 2 low.
  - First clk_out rise and tick occur on the first enabled edge after reset release (latency 1 edge).
- enable[i]=0: count, act, clk_out, state and ratio_err are frozen; tick<=0. On re-enable the channel resumes from the frozen count.
- Channels are fully independent; there is no cross-channel interaction except reset (and sync, if compiled in).
- Maximum ratio is 2^RATIO_W-1; count width is RATIO_W.

Optional Feature:
- Macro CLKDIV_SYNC_EN.
- Defined: adds input port sync_start (1 bit, after ratio). When sync_start=1 at an edge with reset=0, every channel with enable=1 takes a forced period-start edge regardless of count, giving phase-aligned rising edges across channels. Disabled channels ignore it. reset takes priority over sync_start.
- Undefined: the port is absent and there is no forced restart.

Test Plan:
- N_CH=4, ratios {2,3,10,100}, all enabled, reset 1 cycle -> periods 20/30/100/1000 ns at a 10 ns clk_in; high times 10/20/50/500 ns; one tick per period; all rise on the first edge after reset.
- Channel 0 ratio changed 4->6 mid-period at count=1 -> current period completes as 4 cycles; the next period is 6 cycles (3 high, 3 low); no runt pulse.
- Ratio 0, then 1, on channel 1 -> ratio_err=1, clk_out=0, tick=0. Set ratio to 7 -> on the next edge clk_out=1, tick=1, ratio_err=0; period 7 (4 high / 3 low).
- enable[2] dropped for 5 cycles at count=3, ratio 10 -> outputs frozen and no tick; that period stretches to 15 cycles; the next period is back to 10.
- Reset asserted mid-period (ratio all-ones 32-bit, count mid-range) -> next edge: all outputs 0; H computes without overflow (first high phase 2^31 cycles, spot-checked via count).
- CLKDIV_SYNC_EN: ratios {3,5}, pulse sync_start at an arbitrary cycle -> both clk_out rise and both tick on that edge; a disabled channel is unaffected.
